// File: rtl/truth_table_scanner.sv
// truth_table_scanner: clocked sweep of a 4-input function under test.
// Steps the function inputs through minterms 0..15, holds each for SETTLE
// cycles, samples s at the end of each hold, and builds a truth-table word,
// a ones count and a comparison against a latched expected mask.
// The captured word is presented on truth_tbl because "table" is a
// reserved SystemVerilog keyword and cannot be used as a port name.
module truth_table_scanner #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic [3:0]  m,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_tbl,
  output logic [4:0]  ones,
  output logic        match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Settle counter terminal value; SETTLE is legal in 1..15 so it fits 4 bits.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  ones_q, ones_d;
  logic        match_q, match_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    ones_d  = ones_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        m_d = 4'd0;
        if (start) begin
          state_d = SCAN;
          exp_d   = expected;
          tbl_d   = 16'd0;
          ones_d  = 5'd0;
          match_d = 1'b0;
          cnt_d   = 4'd0;
        end
      end
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          tbl_d[m_q] = s;
          ones_d     = ones_q + 5'(s);
          cnt_d      = 4'd0;
          if (m_q == 4'd15) begin
            state_d = DONE;
            m_d     = 4'd0;
            // The final bit is being written this same edge, so splice it in.
            match_d = ({s, tbl_q[14:0]} == exp_q);
          end else begin
            m_d = m_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_d     = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase
    // Status outputs are registered from the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; asynchronous active-low reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= 4'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 16'd0;
      tbl_q   <= 16'd0;
      ones_q  <= 5'd0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x         = m_q[3];
  assign y         = m_q[2];
  assign w         = m_q[1];
  assign z         = m_q[0];
  assign m         = m_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truth_tbl = tbl_q;
  assign ones      = ones_q;
  assign match     = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) are
// driven by a stimulus process that pushes predicted results into per-DUT
// queues; a monitor process pops and compares on every done pulse.
module tb_truth_table_scanner;

  typedef struct packed {
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        match;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [15:0] exp_in [2];
  logic [1:0]  s;
  logic [1:0]  x, y, w, z, busy, done, match;
  logic [3:0]  m [2];
  logic [15:0] tbl [2];
  logic [4:0]  ones [2];

  int          mode_r [2];
  logic [15:0] tt_r [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Function under test: mode 0 is the reference sum-of-products, mode 1 a lookup table.
  function automatic logic fn_eval(int mode, logic [15:0] tt, logic [3:0] v);
    logic fx, fy, fw, fz;
    {fx, fy, fw, fz} = v;
    if (mode == 0)
      return (fw & ~fz) | (~fx & fy & fw) | (~fx & fy & ~fz) | (fx & fy & ~fw & fz);
    return tt[v];
  endfunction

  function automatic exp_t model(int mode, logic [15:0] tt, logic [15:0] ev);
    exp_t e;
    logic b;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      b = fn_eval(mode, tt, 4'(i));
      e.tt[i] = b;
      e.ones = e.ones + 5'(b);
    end
    e.match = (e.tt == ev);
    return e;
  endfunction

  assign s[0] = fn_eval(mode_r[0], tt_r[0], {x[0], y[0], w[0], z[0]});
  assign s[1] = fn_eval(mode_r[1], tt_r[1], {x[1], y[1], w[1], z[1]});

  truth_table_scanner #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .expected(exp_in[0]), .s(s[0]),
    .x(x[0]), .y(y[0]), .w(w[0]), .z(z[0]), .m(m[0]), .busy(busy[0]), .done(done[0]),
    .truth_tbl(tbl[0]), .ones(ones[0]), .match(match[0])
  );

  truth_table_scanner #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .expected(exp_in[1]), .s(s[1]),
    .x(x[1]), .y(y[1]), .w(w[1]), .z(z[1]), .m(m[1]), .busy(busy[1]), .done(done[1]),
    .truth_tbl(tbl[1]), .ones(ones[1]), .match(match[1])
  );

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, req, $time);
    end
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic flush(int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic check_zero(int d);
    chk("rst_m", d, 32'(m[d]), 0);
    chk("rst_xywz", d, 32'({x[d], y[d], w[d], z[d]}), 0);
    chk("rst_busy", d, 32'(busy[d]), 0);
    chk("rst_done", d, 32'(done[d]), 0);
    chk("rst_table", d, 32'(tbl[d]), 0);
    chk("rst_ones", d, 32'(ones[d]), 0);
    chk("rst_match", d, 32'(match[d]), 0);
  endtask

  // Issue a one-cycle start to an idle DUT and record the predicted result.
  task automatic start_scan(int d, int mode, logic [15:0] tt, logic [15:0] ev);
    @(posedge clk); #1;
    mode_r[d] = mode;
    tt_r[d]   = tt;
    exp_in[d] = ev;
    push(d, model(mode, tt, ev));
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    exp_in[d] = ~ev;
  endtask

  task automatic wait_done(int d);
    for (int i = 0; i < 400 && qsize(d) != 0; i++) begin
      @(posedge clk); #1;
    end
    if (qsize(d) != 0) begin
      chk("done_timeout", d, 32'(qsize(d)), 0);
      flush(d);
    end
  endtask

  task automatic wait_m(int d, logic [3:0] target);
    int i;
    for (i = 0; i < 100 && m[d] != target; i++) begin
      @(posedge clk); #1;
    end
    if (m[d] != target) chk("wait_m_timeout", d, 32'(m[d]), 32'(target));
  endtask

  // Monitor: on done, pop and compare; also track busy/done protocol.
  initial begin
    logic [1:0] busy_p, done_p;
    int t_start [2];
    exp_t e;
    busy_p = '0;
    done_p = '0;
    t_start[0] = 0;
    t_start[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_p = '0;
        done_p = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (busy[d] && !busy_p[d]) begin
            t_start[d] = cyc;
            chk("accept_table_clr", d, 32'(tbl[d]), 0);
            chk("accept_ones_clr", d, 32'(ones[d]), 0);
            chk("accept_match_clr", d, 32'(match[d]), 0);
          end
          chk("xywz_is_m", d, 32'({x[d], y[d], w[d], z[d]}), 32'(m[d]));
          if (!busy[d]) chk("idle_m_zero", d, 32'(m[d]), 0);
          if (done[d]) begin
            if (qsize(d) == 0) begin
              chk("unexpected_done", d, 1, 0);
            end else begin
              if (d == 0) e = q0.pop_front();
              else e = q1.pop_front();
              chk("table", d, 32'(tbl[d]), 32'(e.tt));
              chk("ones", d, 32'(ones[d]), 32'(e.ones));
              chk("match", d, 32'(match[d]), 32'(e.match));
              chk("latency", d, 32'(cyc - t_start[d]), 32'(16 * settle(d)));
              chk("busy_at_done", d, 32'(busy[d]), 1);
            end
          end
          if (done_p[d]) begin
            chk("done_one_cycle", d, 32'(done[d]), 0);
            chk("busy_after_done", d, 32'(busy[d]), 0);
          end
          busy_p[d] = busy[d];
          done_p[d] = done[d];
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog vectors=%0d actual=timeout required=finish", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tt, ev;
    mode_r[0] = 1; mode_r[1] = 1;
    tt_r[0] = 16'h0; tt_r[1] = 16'h0;
    exp_in[0] = 16'h0; exp_in[1] = 16'h0;

    // Reset with start high: everything zero, stays idle after release.
    start = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    check_zero(0);
    check_zero(1);
    start = 2'b00;
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy", 0, 32'(busy[0]), 0);
      chk("idle_busy", 1, 32'(busy[1]), 0);
    end

    // Reference function, matching and mismatching masks.
    start_scan(0, 0, 16'h0, 16'h64D4);
    wait_done(0);
    start_scan(0, 0, 16'h0, 16'h64D5);
    exp_in[0] = 16'h64D4;
    wait_done(0);
    start_scan(1, 0, 16'h0, 16'h64D4);
    wait_done(1);

    // Constant functions on the long-settle instance.
    start_scan(1, 1, 16'hFFFF, 16'hFFFF);
    wait_done(1);
    start_scan(1, 1, 16'h0000, 16'h0000);
    wait_done(1);
    start_scan(0, 1, 16'hFFFF, 16'h7FFF);
    wait_done(0);

    // Start pulses mid-scan are ignored.
    for (int d = 0; d < 2; d++) begin
      tt = 16'($urandom);
      start_scan(d, 1, tt, tt);
      wait_m(d, 4'd5);
      start[d] = 1'b1;
      exp_in[d] = ~tt;
      @(posedge clk); #1;
      start[d] = 1'b0;
      wait_done(d);
    end

    // Mid-scan reset, then a fresh scan.
    for (int d = 0; d < 2; d++) begin
      tt = 16'($urandom) | 16'h8001;
      start_scan(d, 1, tt, tt);
      wait_m(d, 4'd9);
      #2 rst_n = 1'b0;
      #1;
      check_zero(d);
      flush(d);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tt = 16'($urandom);
      start_scan(d, 1, tt, 16'($urandom));
      wait_done(d);
    end

    // Back-to-back scans with start held high.
    for (int d = 0; d < 2; d++) begin
      tt = 16'($urandom);
      @(posedge clk); #1;
      mode_r[d] = 1;
      tt_r[d] = tt;
      exp_in[d] = tt;
      push(d, model(1, tt, tt));
      push(d, model(1, tt, tt));
      start[d] = 1'b1;
      for (int i = 0; i < 200 && qsize(d) != 0; i++) begin
        @(posedge clk); #1;
      end
      start[d] = 1'b0;
      if (qsize(d) != 0) begin
        chk("b2b_timeout", d, 32'(qsize(d)), 0);
        flush(d);
      end
    end

    // Randomized functions and masks.
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 2; d++) begin
        tt = 16'($urandom);
        ev = ($urandom_range(0, 1) == 1) ? tt : (tt ^ (16'h1 << $urandom_range(0, 15)));
        start_scan(d, 1, tt, ev);
        wait_done(d);
      end
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
